ntt_stage_ctrl: RTL and testbench

//  Sequencer for the in-place NWC NTT datapath: walks all log2(DEGREE) stages and, per stage, every

---
 rtl/ntt_ctrl_pkg.sv | 15 +
 rtl/ntt_wr_delay.sv | 37 +++
 rtl/ntt_stage_ctrl.sv | 105 ++++++++++
 tb/tb_ntt_stage_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_ctrl_pkg.sv
// Shared types and default geometry for the NTT stage sequencer.
package ntt_ctrl_pkg;

  localparam int DEGREE_DEF   = 1024;
  localparam int BN_DEF       = 16;
  localparam int PIPE_LAT_DEF = 6;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  // Index widths never collapse to zero bits, so MA=1 or STAGES=1 stays legal.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/ntt_wr_delay.sv
// Valid+address delay line that turns each row read into its matching write.
module ntt_wr_delay #(
  parameter int DEPTH = 6,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [AW-1:0] in_addr,
  output logic          out_vld,
  output logic [AW-1:0] out_addr,
  output logic          empty
);

  logic [DEPTH-1:0]         vld_pipe;
  logic [DEPTH-1:0][AW-1:0] addr_pipe;

  // Shifts every cycle, so read bubbles arrive as write gaps at the same offset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[0]  <= in_vld;
      addr_pipe[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  assign out_vld  = vld_pipe[DEPTH-1];
  assign out_addr = addr_pipe[DEPTH-1];
  assign empty    = ~|vld_pipe;

endmodule

// File: rtl/ntt_stage_ctrl.sv
// Stage/row sequencer for the in-place NTT: issues row reads, trailing writes and done.
module ntt_stage_ctrl
  import ntt_ctrl_pkg::*;
#(
  parameter int DEGREE   = DEGREE_DEF,
  parameter int BN       = BN_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int MA       = DEGREE / BN,
  parameter int STAGES   = $clog2(DEGREE),
  parameter int AW       = clog2_min1(MA),
  parameter int SW       = clog2_min1(STAGES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          tf_ready,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_wr_addr,
  output logic          tf_en,
  output logic [SW-1:0] stage_idx,
  output logic [AW-1:0] row_idx,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] ROW_LAST   = AW'(MA - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(STAGES - 1);

  state_t        state;
  logic [AW-1:0] row;
  logic [SW-1:0] stage;
  logic          rd;
  logic          wr_empty;

  assign rd          = (state == READ) && tf_ready;
  assign mem_rd_en   = rd;
  assign tf_en       = rd;
  assign mem_rd_addr = row;
  assign row_idx     = row;
  assign stage_idx   = stage;

  // Row only returns to 0 on a stage transition, so DRAIN keeps the last row visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      stage <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= READ;
            busy  <= 1'b1;
            stage <= '0;
            row   <= '0;
          end
        end
        READ: begin
          if (rd) begin
            if (row == ROW_LAST) state <= DRAIN;
            else                 row   <= row + 1'b1;
          end
        end
        DRAIN: begin
          // Waiting for an empty delay line keeps next-stage reads behind this stage's writes.
          if (wr_empty) begin
            if (stage == STAGE_LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= READ;
              stage <= stage + 1'b1;
              row   <= '0;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  ntt_wr_delay #(
    .DEPTH (PIPE_LAT),
    .AW    (AW)
  ) u_wr_delay (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rd),
    .in_addr  (row),
    .out_vld  (mem_wr_en),
    .out_addr (mem_wr_addr),
    .empty    (wr_empty)
  );

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Bench for ntt_stage_ctrl: cycle model of the read/write schedule plus directed scenarios.
module tb_ntt_stage_ctrl;

  localparam int PL = 6;
  localparam int MA = 64;
  localparam int ST = 10;

  logic       clk = 1'b0;
  logic       rst, start, tf_ready, start_s;
  logic       mem_rd_en, mem_wr_en, tf_en, busy, done;
  logic [5:0] mem_rd_addr, mem_wr_addr, row_idx;
  logic [3:0] stage_idx;
  logic       s_rd_en, s_wr_en, s_tf_en, s_busy, s_done;
  logic [0:0] s_rd_addr, s_wr_addr, s_row_idx;
  logic [2:0] s_stage_idx;

  always #5 clk = ~clk;

  ntt_stage_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .tf_ready(tf_ready),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .tf_en(tf_en), .stage_idx(stage_idx), .row_idx(row_idx),
    .busy(busy), .done(done)
  );

  ntt_stage_ctrl #(.DEGREE(32), .BN(16)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .tf_ready(tf_ready),
    .mem_rd_en(s_rd_en), .mem_rd_addr(s_rd_addr),
    .mem_wr_en(s_wr_en), .mem_wr_addr(s_wr_addr),
    .tf_en(s_tf_en), .stage_idx(s_stage_idx), .row_idx(s_row_idx),
    .busy(s_busy), .done(s_done)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is ST stages of MA reads; after a stage's last read, PL+1 idle cycles follow.
  bit m_busy, m_done;
  int m_stage, m_row, m_wait;
  bit hist_v [PL];
  int hist_a [PL];
  int run_cyc, gcyc, done_at, first_wr_at, rd5_at, wr5_at;
  int rd_cnt, wr_cnt, done_cnt, stage_steps, prev_stage, last_w63;

  always @(negedge clk) begin
    bit e_rd;
    gcyc++;
    run_cyc++;
    if (rst) begin
      chk("rst_outputs", {mem_rd_en, mem_wr_en, tf_en, busy, done, mem_rd_addr,
                          mem_wr_addr, row_idx, stage_idx}, 0);
      m_busy = 0; m_done = 0; m_stage = 0; m_row = 0; m_wait = 0;
      for (int i = 0; i < PL; i++) begin hist_v[i] = 0; hist_a[i] = 0; end
      wr_cnt = 0;
    end else begin
      e_rd = m_busy && (m_row < MA) && tf_ready;
      chk("rd_en", mem_rd_en, e_rd);
      chk("tf_en", tf_en, e_rd);
      chk("wr_en", mem_wr_en, hist_v[PL-1]);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (e_rd) begin
        chk("rd_addr", mem_rd_addr, m_row);
        chk("row_idx", row_idx, m_row);
      end
      if (hist_v[PL-1]) chk("wr_addr", mem_wr_addr, hist_a[PL-1]);
      if (m_busy) chk("stage_idx", stage_idx, m_stage);

      // Observed-trace bookkeeping for the directed scenarios.
      if (mem_rd_en) begin
        rd_cnt++;
        if (mem_rd_addr == 0 && stage_idx != 0) chk("hazard_order", gcyc > last_w63, 1);
        if (mem_rd_addr == 5 && stage_idx == 0) rd5_at = run_cyc;
      end
      if (mem_wr_en) begin
        wr_cnt++;
        if (first_wr_at < 0) first_wr_at = run_cyc;
        if (mem_wr_addr == 63) last_w63 = gcyc;
        if (mem_wr_addr == 5 && stage_idx == 0) wr5_at = run_cyc;
      end
      if (busy && stage_idx != prev_stage) begin
        chk("stage_step", stage_idx, prev_stage + 1);
        stage_steps++;
        prev_stage = stage_idx;
      end
      if (done) begin done_cnt++; done_at = run_cyc; end

      // Advance the model across the coming edge.
      for (int i = PL - 1; i > 0; i--) begin hist_v[i] = hist_v[i-1]; hist_a[i] = hist_a[i-1]; end
      hist_v[0] = e_rd;
      hist_a[0] = m_row;
      if (m_done) m_done = 0;
      else if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_stage = 0; m_row = 0; m_wait = 0;
          run_cyc = 0; rd_cnt = 0; wr_cnt = 0; done_cnt = 0; stage_steps = 0;
          prev_stage = 0; done_at = -1; first_wr_at = -1; rd5_at = -1; wr5_at = -1;
        end
      end else if (e_rd) begin
        m_row++;
        if (m_row == MA) m_wait = PL + 1;
      end else if (m_row == MA) begin
        if (m_wait == 1) begin
          if (m_stage == ST - 1) begin m_busy = 0; m_done = 1; end
          else begin m_stage++; m_row = 0; end
        end
        m_wait--;
      end
    end
  end

  // Leaves the bench in cycle 1 of the new run (start sampled on the edge closing cycle 0).
  task automatic do_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input string name, input int lim);
    bit got = 0;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    chk(name, got, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int s_rd, s_wr, s_bad, s_done_at;
    gcyc = 0; last_w63 = -1;
    rst = 1; start = 0; start_s = 0; tf_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_rd_en", mem_rd_en, 0);
    chk("reset_stage", stage_idx, 0);
    rst = 0;

    // 1: stall-free run
    do_start();
    wait_done("t1_done_seen", 800);
    chk("t1_done_cycle", done_at, ST * (MA + PL + 1) + 1);
    chk("t1_done_cycle_lit", done_at, 711);
    chk("t1_first_write", first_wr_at, 7);
    chk("t1_reads", rd_cnt, 640);
    chk("t1_writes", wr_cnt, 640);
    chk("t1_stage_steps", stage_steps, 9);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_busy_after", busy, 0);

    // 2: three-cycle stall at rows 5..7 of stage 0
    do_start();
    repeat (5) @(posedge clk);
    #1 tf_ready = 0;
    repeat (3) @(posedge clk);
    #1 tf_ready = 1;
    wait_done("t2_done_seen", 800);
    chk("t2_row5_read", rd5_at, 9);
    chk("t2_row5_write", wr5_at, 15);
    chk("t2_done_cycle", done_at, 714);
    chk("t2_reads", rd_cnt, 640);

    // 4: start pulse in stage 3 is ignored
    do_start();
    repeat (229) @(posedge clk);
    #1 start = 1;
    @(posedge clk); #1 start = 0;
    wait_done("t4_done_seen", 800);
    chk("t4_done_cycle", done_at, 711);
    chk("t4_done_pulses", done_cnt, 1);

    // 5: reset during a stage-5 read
    do_start();
    repeat (379) @(posedge clk);
    #1;
    chk("t5_reading", mem_rd_en, 1);
    chk("t5_stage", stage_idx, 5);
    rst = 1;
    #1;
    chk("t5_async_clear", {mem_rd_en, mem_wr_en, tf_en, busy, done, mem_rd_addr,
                           mem_wr_addr, row_idx, stage_idx}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("t5_no_writes", wr_cnt, 0);
    do_start();
    wait_done("t5_rerun_done_seen", 800);
    chk("t5_rerun_done_cycle", done_at, 711);

    // 6: small configuration, MA=2, 5 stages
    @(posedge clk); #1 start_s = 1;
    @(posedge clk); #1 start_s = 0;
    s_rd = 0; s_wr = 0; s_bad = 0; s_done_at = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (s_rd_en) begin
        if (s_rd_addr != 1'(s_rd % 2)) s_bad++;
        s_rd++;
      end
      if (s_wr_en) begin
        if (s_wr_addr != 1'(s_wr % 2)) s_bad++;
        s_wr++;
      end
      if (s_done && s_done_at < 0) s_done_at = k;
    end
    chk("t6_done_cycle", s_done_at, 46);
    chk("t6_reads", s_rd, 10);
    chk("t6_writes", s_wr, 10);
    chk("t6_addr_order", s_bad, 0);
    chk("t6_busy_after", s_busy, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
